fir_coef_bank_ctrl: RTL and testbench

//  Coefficient configuration controller for a chain of TAPS systolic FIR taps.

---
 rtl/fir_coef_bank_ctrl.sv | 118 +++++++++++
 tb/tb_fir_coef_bank_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_bank_ctrl.sv
// Coefficient bank controller for a systolic FIR tap chain: shadow bank writes, swap into active bank on a sample boundary.
// Optional shadow-bank readback port enabled by defining FIR_COEF_READBACK_EN.
module fir_coef_bank_ctrl #(
  parameter int BITS   = 16,
  parameter int TAPS   = 8,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BITS-1:0]      wr_data,
  input  logic                 commit,
  input  logic                 sample_strobe,
  output logic [TAPS*BITS-1:0] coef_flat,
  output logic                 busy,
  output logic                 swap_done,
`ifdef FIR_COEF_READBACK_EN
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [BITS-1:0]      rd_data,
`endif
  output logic                 addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SWAP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [BITS-1:0] shadow [TAPS];
  logic            wr_fire;
  logic            wr_in_range;
  logic            commit_take;

  assign wr_fire     = wr_valid & wr_ready;
  assign wr_in_range = 32'(wr_addr) < TAPS;
  assign commit_take = commit & (state_q == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A strobe is only looked at from PEND, so one coinciding with the commit never counts.
  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
        busy     = 1'b0;
        if (commit) state_d = PEND;
      end
      PEND: begin
        if (sample_strobe) state_d = SWAP;
      end
      SWAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TAPS; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (wr_fire && (32'(wr_addr) == i)) shadow[i] <= wr_data;
      end
    end
  end

  // Writes are stalled outside IDLE, so the shadow bank is stable while it is copied.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_flat <= '0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= (state_q == SWAP);
      if (state_q == SWAP) begin
        for (int i = 0; i < TAPS; i++) coef_flat[i*BITS +: BITS] <= shadow[i];
      end
    end
  end

  // Setting wins over the commit clear when both happen in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        addr_err <= 1'b0;
    else if (wr_fire && !wr_in_range) addr_err <= 1'b1;
    else if (commit_take)             addr_err <= 1'b0;
  end

`ifdef FIR_COEF_READBACK_EN
  logic [BITS-1:0] rd_next;

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (32'(rd_addr) == i) rd_next = shadow[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data <= '0;
    else       rd_data <= rd_next;
  end
`endif

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed self-checking bench for fir_coef_bank_ctrl (TAPS=8, BITS=16, ADDR_W=4 so out-of-range addresses are reachable).
// Readback checks run only when FIR_COEF_READBACK_EN is defined.
module tb_fir_coef_bank_ctrl;

  localparam int BITS   = 16;
  localparam int TAPS   = 8;
  localparam int ADDR_W = 4;

  logic                 clk;
  logic                 rstn;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_W-1:0]    wr_addr;
  logic [BITS-1:0]      wr_data;
  logic                 commit;
  logic                 sample_strobe;
  logic [TAPS*BITS-1:0] coef_flat;
  logic                 busy;
  logic                 swap_done;
  logic                 addr_err;
`ifdef FIR_COEF_READBACK_EN
  logic [ADDR_W-1:0]    rd_addr;
  logic [BITS-1:0]      rd_data;
`endif

  int pass_count;
  int check_count;
  logic [TAPS*BITS-1:0] exp_flat;

  fir_coef_bank_ctrl #(
    .BITS  (BITS),
    .TAPS  (TAPS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .sample_strobe(sample_strobe),
    .coef_flat    (coef_flat),
    .busy         (busy),
    .swap_done    (swap_done),
`ifdef FIR_COEF_READBACK_EN
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
`endif
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the edge, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; sample_strobe = 1'b0;
`ifdef FIR_COEF_READBACK_EN
    rd_addr = '0;
`endif
    exp_flat = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    check_count++;
    if (coef_flat !== '0) $display("[TB] FAIL reset_coef actual=%h required=0", coef_flat);
    else pass_count++;
    check_count++;
    if (wr_ready !== 1'b1) $display("[TB] FAIL reset_wr_ready actual=%b required=1", wr_ready);
    else pass_count++;
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy actual=%b required=0", busy);
    else pass_count++;
    check_count++;
    if (addr_err !== 1'b0) $display("[TB] FAIL reset_addr_err actual=%b required=0", addr_err);
    else pass_count++;
    check_count++;
    if (swap_done !== 1'b0) $display("[TB] FAIL reset_swap_done actual=%b required=0", swap_done);
    else pass_count++;
`ifdef FIR_COEF_READBACK_EN
    check_count++;
    if (rd_data !== '0) $display("[TB] FAIL reset_rd_data actual=%h required=0", rd_data);
    else pass_count++;
`endif
  endtask

  task automatic test_swap();
    logic [TAPS*BITS-1:0] old_flat;
    old_flat = exp_flat;
    for (int i = 0; i < TAPS; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'(i); wr_data = 16'h3C00 + 16'(i);
      exp_flat[i*BITS +: BITS] = 16'h3C00 + 16'(i);
      tick();
    end
    wr_valid = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check_count++;
    if (busy !== 1'b1 || wr_ready !== 1'b0)
      $display("[TB] FAIL swap_pend_flags actual busy=%b ready=%b required busy=1 ready=0", busy, wr_ready);
    else pass_count++;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_count++;
      if (coef_flat !== old_flat) $display("[TB] FAIL swap_hold_c%0d actual=%h required=%h", c, coef_flat, old_flat);
      else pass_count++;
    end
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    check_count++;
    if (coef_flat !== old_flat || busy !== 1'b1 || swap_done !== 1'b0)
      $display("[TB] FAIL swap_state actual coef=%h busy=%b done=%b required coef=%h busy=1 done=0",
               coef_flat, busy, swap_done, old_flat);
    else pass_count++;
    tick();
    check_count++;
    if (coef_flat !== exp_flat) $display("[TB] FAIL swap_coef actual=%h required=%h", coef_flat, exp_flat);
    else pass_count++;
    check_count++;
    if (swap_done !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL swap_done_pulse actual done=%b busy=%b required done=1 busy=0", swap_done, busy);
    else pass_count++;
    tick();
    check_count++;
    if (swap_done !== 1'b0) $display("[TB] FAIL swap_done_width actual=%b required=0", swap_done);
    else pass_count++;
  endtask

  task automatic test_same_cycle_strobe();
    int busy_cycles;
    logic [TAPS*BITS-1:0] old_flat;
    old_flat = exp_flat;
    busy_cycles = 0;
    // Write in the commit cycle must be part of the swap; the coinciding strobe must not count.
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 16'hABCD;
    commit = 1'b1; sample_strobe = 1'b1;
    exp_flat[2*BITS +: BITS] = 16'hABCD;
    tick();
    wr_valid = 1'b0; commit = 1'b0; sample_strobe = 1'b0;
    if (busy === 1'b1) busy_cycles++;
    for (int c = 0; c < 9; c++) begin
      commit = (c == 4);
      tick();
      if (busy === 1'b1) busy_cycles++;
    end
    commit = 1'b0;
    check_count++;
    if (coef_flat !== old_flat) $display("[TB] FAIL same_cycle_hold actual=%h required=%h", coef_flat, old_flat);
    else pass_count++;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    if (busy === 1'b1) busy_cycles++;
    tick();
    if (busy === 1'b1) busy_cycles++;
    check_count++;
    if (busy_cycles !== 11) $display("[TB] FAIL same_cycle_busy_len actual=%0d required=11", busy_cycles);
    else pass_count++;
    check_count++;
    if (coef_flat !== exp_flat || swap_done !== 1'b1)
      $display("[TB] FAIL same_cycle_swap actual coef=%h done=%b required coef=%h done=1", coef_flat, swap_done, exp_flat);
    else pass_count++;
    tick();
    check_count++;
    if (busy !== 1'b0) $display("[TB] FAIL no_queued_swap actual busy=%b required=0", busy);
    else pass_count++;
  endtask

  task automatic test_addr_err();
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'hFFFF;
    tick();
    wr_valid = 1'b0;
    check_count++;
    if (addr_err !== 1'b1) $display("[TB] FAIL addr_err_set actual=%b required=1", addr_err);
    else pass_count++;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check_count++;
    if (addr_err !== 1'b0) $display("[TB] FAIL addr_err_clear actual=%b required=0", addr_err);
    else pass_count++;
    sample_strobe = 1'b1; tick(); sample_strobe = 1'b0; tick();
    check_count++;
    if (coef_flat !== exp_flat) $display("[TB] FAIL addr_err_no_write actual=%h required=%h", coef_flat, exp_flat);
    else pass_count++;
    wr_valid = 1'b1; wr_addr = 4'd15; wr_data = 16'hFFFF; commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    check_count++;
    if (addr_err !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL addr_err_with_commit actual err=%b busy=%b required err=1 busy=1", addr_err, busy);
    else pass_count++;
    sample_strobe = 1'b1; tick(); sample_strobe = 1'b0; tick();
    check_count++;
    if (coef_flat !== exp_flat || addr_err !== 1'b1)
      $display("[TB] FAIL addr_err_sticky actual coef=%h err=%b required coef=%h err=1", coef_flat, addr_err, exp_flat);
    else pass_count++;
  endtask

  task automatic test_stall_and_reset();
    logic [TAPS*BITS-1:0] old_flat;
    old_flat = exp_flat;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555;
    tick();
    check_count++;
    if (wr_ready !== 1'b0) $display("[TB] FAIL stall_ready actual=%b required=0", wr_ready);
    else pass_count++;
    sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
    tick();
    check_count++;
    if (swap_done !== 1'b1 || wr_ready !== 1'b1 || coef_flat !== old_flat)
      $display("[TB] FAIL stall_swap actual done=%b ready=%b coef=%h required done=1 ready=1 coef=%h",
               swap_done, wr_ready, coef_flat, old_flat);
    else pass_count++;
    tick();
    wr_valid = 1'b0;
    exp_flat[5*BITS +: BITS] = 16'h5555;
    commit = 1'b1; tick(); commit = 1'b0;
    sample_strobe = 1'b1; tick(); sample_strobe = 1'b0; tick();
    check_count++;
    if (coef_flat !== exp_flat) $display("[TB] FAIL stall_landed actual=%h required=%h", coef_flat, exp_flat);
    else pass_count++;
    // Reset mid-PEND: everything clears and the pending swap is abandoned.
    commit = 1'b1; tick(); commit = 1'b0;
    rstn = 1'b0;
    #2;
    check_count++;
    if (coef_flat !== '0 || busy !== 1'b0 || wr_ready !== 1'b1)
      $display("[TB] FAIL pend_reset actual coef=%h busy=%b ready=%b required coef=0 busy=0 ready=1",
               coef_flat, busy, wr_ready);
    else pass_count++;
    #1;
    rstn = 1'b1;
    exp_flat = '0;
    for (int c = 0; c < 3; c++) begin
      sample_strobe = (c == 0);
      tick();
      check_count++;
      if (swap_done !== 1'b0 || coef_flat !== '0)
        $display("[TB] FAIL pend_reset_no_swap_c%0d actual done=%b coef=%h required done=0 coef=0", c, swap_done, coef_flat);
      else pass_count++;
    end
    sample_strobe = 1'b0;
    commit = 1'b1; tick(); commit = 1'b0;
    sample_strobe = 1'b1; tick(); sample_strobe = 1'b0; tick();
    check_count++;
    if (coef_flat !== '0 || swap_done !== 1'b1)
      $display("[TB] FAIL shadow_cleared actual coef=%h done=%b required coef=0 done=1", coef_flat, swap_done);
    else pass_count++;
  endtask

`ifdef FIR_COEF_READBACK_EN
  task automatic test_readback();
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234; rd_addr = 4'd3;
    tick();
    wr_valid = 1'b0;
    check_count++;
    if (rd_data !== 16'h0000) $display("[TB] FAIL rd_same_cycle actual=%h required=0000", rd_data);
    else pass_count++;
    tick();
    check_count++;
    if (rd_data !== 16'h1234) $display("[TB] FAIL rd_tap3 actual=%h required=1234", rd_data);
    else pass_count++;
    rd_addr = 4'd8;
    tick();
    check_count++;
    if (rd_data !== 16'h0000) $display("[TB] FAIL rd_out_of_range actual=%h required=0000", rd_data);
    else pass_count++;
  endtask
`endif

  initial begin
    pass_count  = 0;
    check_count = 0;
    test_reset();
    test_swap();
    test_same_cycle_strobe();
    test_addr_err();
    test_stall_and_reset();
`ifdef FIR_COEF_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
